// File: rtl/ddr_ctrl_pkg.sv
// Shared definitions for the DDR write/read burst schedulers.
//   ADDR_W           : byte-address width of the frame buffers
//   sched_state_t    : scheduler FSM encoding (IDLE / START / BURST)
//   calc_burst_bytes : bytes moved by one burst of (burst_len+1) beats
package ddr_ctrl_pkg;

  localparam int ADDR_W = 29;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BURST = 2'd2
  } sched_state_t;

  function automatic logic [ADDR_W-1:0] calc_burst_bytes(input int burst_len, input int axi_width);
    int bytes;
    bytes = (burst_len + 1) * axi_width / 8;
    return bytes[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/ddr_wr_arbiter_if.sv
// Command/data bus between the write scheduler and the AXI4 write master.
//   wr_ready    : master idle, may accept a burst request
//   wr_done     : master burst-complete pulse
//   w_handshake : master accepted one W beat this cycle
//   wr_start    : burst request pulse
//   wr_addr     : burst byte address
//   wr_len      : burst awlen
//   wr_data     : W data presented to the master
// Modport master = scheduler side, slave = write-master side.
interface ddr_wr_arbiter_if #(
  parameter int AXI_WIDTH = 256
) ();

  logic                              wr_ready;
  logic                              wr_done;
  logic                              w_handshake;
  logic                              wr_start;
  logic [ddr_ctrl_pkg::ADDR_W-1:0]   wr_addr;
  logic [7:0]                        wr_len;
  logic [AXI_WIDTH-1:0]              wr_data;

  modport master (
    input  wr_ready, wr_done, w_handshake,
    output wr_start, wr_addr, wr_len, wr_data
  );

  modport slave (
    output wr_ready, wr_done, w_handshake,
    input  wr_start, wr_addr, wr_len, wr_data
  );

endinterface

// File: rtl/frame_addr_gen.sv
// Per-channel frame-buffer address pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   frame_rst  : pulse, re-base the pointer to BASE
//   active     : this channel currently owns a burst
//   done       : burst of this channel completed this cycle
//   ptr        : byte address for the next burst of this channel
// The pointer advances by STEP on each completed burst and wraps to BASE at
// the end of the frame. A frame reset during an owned burst is deferred to
// that burst's completion so the burst finishes at its original address.
module frame_addr_gen
  import ddr_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE        = '0,
  parameter logic [ADDR_W-1:0] FRAME_BYTES = 29'h018_0000,
  parameter logic [ADDR_W-1:0] STEP        = 29'h000_0400
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_rst,
  input  logic              active,
  input  logic              done,
  output logic [ADDR_W-1:0] ptr
);

  localparam logic [ADDR_W-1:0] FRAME_END = BASE + FRAME_BYTES;

  logic [ADDR_W-1:0] ptr_next;
  logic              rst_pend;

  assign ptr_next = ptr + STEP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= BASE;
      rst_pend <= 1'b0;
    end else if (done) begin
      // A frame reset (pending or arriving now) overrides the increment.
      if (frame_rst || rst_pend || (ptr_next >= FRAME_END)) begin
        ptr <= BASE;
      end else begin
        ptr <= ptr_next;
      end
      rst_pend <= 1'b0;
    end else if (frame_rst) begin
      if (active) begin
        rst_pend <= 1'b1;
      end else begin
        ptr <= BASE;
      end
    end
  end

endmodule

// File: rtl/ddr_wr_arbiter.sv
// Two-channel round-robin write scheduler in front of the AXI4 write master.
//   clk, rst_n          : clock, asynchronous active-low reset
//   enable              : allow new grants
//   chN_fifo_cnt        : words available in camera FIFO N
//   chN_fifo_dout       : FWFT head word of FIFO N
//   chN_fifo_rd_en      : pop FIFO N (one per accepted W beat)
//   chN_frame_rst       : pulse, re-base channel N frame pointer
//   wr_bus (master)     : burst command / data bus to the write master
//   grant               : one-hot owning channel, 00 when idle
//   beat_err            : sticky, a burst saw a beat count other than BURST_LEN+1
module ddr_wr_arbiter
  import ddr_ctrl_pkg::*;
#(
  parameter int                AXI_WIDTH   = 256,
  parameter int                FIFO_CNT_W  = 10,
  parameter logic [7:0]        BURST_LEN   = 8'd31,
  parameter logic [ADDR_W-1:0] CH0_BASE    = 29'h000_0000,
  parameter logic [ADDR_W-1:0] CH1_BASE    = 29'h100_0000,
  parameter logic [ADDR_W-1:0] FRAME_BYTES = 29'h018_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [FIFO_CNT_W-1:0] ch0_fifo_cnt,
  input  logic [AXI_WIDTH-1:0]  ch0_fifo_dout,
  output logic                  ch0_fifo_rd_en,
  input  logic                  ch0_frame_rst,
  input  logic [FIFO_CNT_W-1:0] ch1_fifo_cnt,
  input  logic [AXI_WIDTH-1:0]  ch1_fifo_dout,
  output logic                  ch1_fifo_rd_en,
  input  logic                  ch1_frame_rst,
  ddr_wr_arbiter_if.master      wr_bus,
  output logic [1:0]            grant,
  output logic                  beat_err
);

  localparam logic [ADDR_W-1:0]     BURST_BYTES = calc_burst_bytes(int'(BURST_LEN), AXI_WIDTH);
  localparam logic [FIFO_CNT_W:0]   REQ_LVL     = (FIFO_CNT_W+1)'(int'(BURST_LEN) + 1);
  localparam logic [8:0]            BEATS       = 9'(int'(BURST_LEN) + 1);

  sched_state_t      state;
  logic              last_ch1;
  logic [8:0]        beat_cnt;
  logic [8:0]        beat_total;
  logic              req0;
  logic              req1;
  logic              pick_ch1;
  logic              in_burst;
  logic              done0;
  logic              done1;
  logic [ADDR_W-1:0] ptr0;
  logic [ADDR_W-1:0] ptr1;

  assign req0     = {1'b0, ch0_fifo_cnt} >= REQ_LVL;
  assign req1     = {1'b0, ch1_fifo_cnt} >= REQ_LVL;
  // Alternate when both request; otherwise serve whoever asks.
  assign pick_ch1 = req1 & (~req0 | ~last_ch1);
  assign in_burst = (state == ST_BURST);
  assign done0    = wr_bus.wr_done & in_burst & grant[0];
  assign done1    = wr_bus.wr_done & in_burst & grant[1];
  // A beat accepted in the completion cycle still belongs to this burst.
  assign beat_total = beat_cnt + {8'd0, wr_bus.w_handshake};

  frame_addr_gen #(
    .BASE        (CH0_BASE),
    .FRAME_BYTES (FRAME_BYTES),
    .STEP        (BURST_BYTES)
  ) u_ch0_addr (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_rst (ch0_frame_rst),
    .active    (grant[0]),
    .done      (done0),
    .ptr       (ptr0)
  );

  frame_addr_gen #(
    .BASE        (CH1_BASE),
    .FRAME_BYTES (FRAME_BYTES),
    .STEP        (BURST_BYTES)
  ) u_ch1_addr (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_rst (ch1_frame_rst),
    .active    (grant[1]),
    .done      (done1),
    .ptr       (ptr1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      grant           <= 2'b00;
      last_ch1        <= 1'b1;
      beat_cnt        <= '0;
      beat_err        <= 1'b0;
      wr_bus.wr_start <= 1'b0;
      wr_bus.wr_addr  <= '0;
    end else begin
      wr_bus.wr_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable && wr_bus.wr_ready && (req0 || req1)) begin
            grant          <= pick_ch1 ? 2'b10 : 2'b01;
            wr_bus.wr_addr <= pick_ch1 ? ptr1 : ptr0;
            state          <= ST_START;
          end
        end
        ST_START: begin
          wr_bus.wr_start <= 1'b1;
          beat_cnt        <= '0;
          state           <= ST_BURST;
        end
        ST_BURST: begin
          if (wr_bus.w_handshake) begin
            beat_cnt <= beat_cnt + 9'd1;
          end
          if (wr_bus.wr_done) begin
            if (beat_total != BEATS) begin
              beat_err <= 1'b1;
            end
            last_ch1 <= grant[1];
            grant    <= 2'b00;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign wr_bus.wr_len  = BURST_LEN;
  assign wr_bus.wr_data = grant[0] ? ch0_fifo_dout : ch1_fifo_dout;
  assign ch0_fifo_rd_en = wr_bus.w_handshake & grant[0] & in_burst;
  assign ch1_fifo_rd_en = wr_bus.w_handshake & grant[1] & in_burst;

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// Testbench for ddr_wr_arbiter: FIFO and write-master models, a reference
// scheduler/address model feeding a scoreboard, and a decoupled monitor.
module tb_ddr_wr_arbiter;
  import ddr_ctrl_pkg::*;

  localparam int          AW     = 256;
  localparam int          CW     = 10;
  localparam logic [7:0]  BL     = 8'd31;
  localparam int          BEATS  = 32;
  localparam logic [28:0] B0     = 29'h000_0000;
  localparam logic [28:0] B1     = 29'h100_0000;
  localparam logic [28:0] FRAME  = 29'h000_1000;
  localparam logic [28:0] BBYTES = 29'h000_0400;

  typedef struct packed {
    logic        ch;
    logic [28:0] addr;
  } burst_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [CW-1:0] ch0_fifo_cnt = '0;
  logic [CW-1:0] ch1_fifo_cnt = '0;
  logic [AW-1:0] ch0_fifo_dout = '0;
  logic [AW-1:0] ch1_fifo_dout = '0;
  logic          ch0_fifo_rd_en, ch1_fifo_rd_en;
  logic          ch0_frame_rst = 1'b0;
  logic          ch1_frame_rst = 1'b0;
  logic [1:0]    grant;
  logic          beat_err;

  ddr_wr_arbiter_if #(.AXI_WIDTH(AW)) bus ();

  ddr_wr_arbiter #(
    .AXI_WIDTH   (AW),
    .FIFO_CNT_W  (CW),
    .BURST_LEN   (BL),
    .CH0_BASE    (B0),
    .CH1_BASE    (B1),
    .FRAME_BYTES (FRAME)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .ch0_fifo_cnt   (ch0_fifo_cnt),
    .ch0_fifo_dout  (ch0_fifo_dout),
    .ch0_fifo_rd_en (ch0_fifo_rd_en),
    .ch0_frame_rst  (ch0_frame_rst),
    .ch1_fifo_cnt   (ch1_fifo_cnt),
    .ch1_fifo_dout  (ch1_fifo_dout),
    .ch1_fifo_rd_en (ch1_fifo_rd_en),
    .ch1_frame_rst  (ch1_frame_rst),
    .wr_bus         (bus),
    .grant          (grant),
    .beat_err       (beat_err)
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // FIFO contents (environment) and reference model state
  logic [AW-1:0] fifo0[$];
  logic [AW-1:0] fifo1[$];
  logic [AW-1:0] dataq0[$];
  logic [AW-1:0] dataq1[$];
  burst_t        exp_burst[$];
  logic [AW-1:0] exp_beat[$];
  logic [28:0]   mptr[2];
  logic          mlast;

  int nbeats_cfg = BEATS;
  bit mst_busy = 1'b0;
  int beats_left = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // FIFO model + write-master model, updated 1 time unit after each edge.
  initial begin
    bit p0, p1, st;
    bus.wr_ready    = 1'b1;
    bus.wr_done     = 1'b0;
    bus.w_handshake = 1'b0;
    forever begin
      @(negedge clk);
      p0 = ch0_fifo_rd_en;
      p1 = ch1_fifo_rd_en;
      st = bus.wr_start;
      @(posedge clk);
      #1;
      bus.w_handshake = 1'b0;
      bus.wr_done     = 1'b0;
      if (!rst_n) begin
        mst_busy     = 1'b0;
        bus.wr_ready = 1'b1;
      end else begin
        if (p0 && fifo0.size() > 0) void'(fifo0.pop_front());
        if (p1 && fifo1.size() > 0) void'(fifo1.pop_front());
        if (!mst_busy) begin
          if (st) begin
            mst_busy     = 1'b1;
            beats_left   = nbeats_cfg;
            bus.wr_ready = 1'b0;
          end
        end else if (beats_left > 0) begin
          if ($urandom_range(0, 3) != 0) begin
            bus.w_handshake = 1'b1;
            beats_left--;
          end
        end else begin
          bus.wr_done  = 1'b1;
          mst_busy     = 1'b0;
          bus.wr_ready = 1'b1;
        end
      end
      ch0_fifo_cnt  = CW'(fifo0.size());
      ch1_fifo_cnt  = CW'(fifo1.size());
      ch0_fifo_dout = (fifo0.size() > 0) ? fifo0[0] : '0;
      ch1_fifo_dout = (fifo1.size() > 0) ? fifo1[0] : '0;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a burst or beat.
  logic        cur_ch = 1'b0;
  logic [28:0] cur_addr = '0;
  int n_start = 0;
  int n_rd0 = 0;

  always @(negedge clk) begin
    burst_t e;
    if (rst_n) begin
      if (ch0_fifo_rd_en) n_rd0++;
      if (bus.wr_start) begin
        n_start++;
        if (exp_burst.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_start: got wr_start addr %0h grant %b, required no burst", bus.wr_addr, grant);
        end else begin
          e = exp_burst.pop_front();
          cur_ch   = e.ch;
          cur_addr = e.addr;
          chk("start_grant", grant, e.ch ? 2'b10 : 2'b01);
          chk("start_addr", bus.wr_addr, e.addr);
          chk("start_len", bus.wr_len, BL);
        end
      end
      if (bus.w_handshake) begin
        chk("rd_en", {ch1_fifo_rd_en, ch0_fifo_rd_en}, cur_ch ? 2'b10 : 2'b01);
        if (exp_beat.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_beat: got data %0h, required no beat", bus.wr_data);
        end else begin
          chk("wr_data", bus.wr_data, exp_beat.pop_front());
        end
      end
      if (bus.wr_done) chk("addr_hold", bus.wr_addr, cur_addr);
    end
  end

  task automatic push_words(input bit ch, input int n);
    logic [AW-1:0] w;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < AW / 32; j++) w[j*32 +: 32] = $urandom;
      if (ch) begin fifo1.push_back(w); dataq1.push_back(w); end
      else    begin fifo0.push_back(w); dataq0.push_back(w); end
    end
  endtask

  // Reference: burst goes to the channel's pointer; pointer advances a burst
  // and returns to base once it reaches base + frame size.
  task automatic expect_burst(input bit ch);
    burst_t      e;
    logic [28:0] base;
    logic [28:0] nxt;
    e.ch   = ch;
    e.addr = mptr[ch];
    exp_burst.push_back(e);
    for (int i = 0; i < BEATS; i++)
      exp_beat.push_back(ch ? dataq1.pop_front() : dataq0.pop_front());
    base     = ch ? B1 : B0;
    nxt      = mptr[ch] + BBYTES;
    mptr[ch] = (nxt >= base + FRAME) ? base : nxt;
    mlast    = ch;
  endtask

  // Round-robin order for n0/n1 bursts pending on the two channels.
  task automatic schedule(input int n0, input int n1);
    int  r0, r1;
    bit  pick;
    r0 = n0;
    r1 = n1;
    while (r0 > 0 || r1 > 0) begin
      if (r0 > 0 && r1 > 0) pick = ~mlast;
      else                  pick = (r1 > 0);
      expect_burst(pick);
      if (pick) r1--; else r0--;
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_burst.size() != 0 || exp_beat.size() != 0 || mst_busy || grant != 2'b00) && k < 5000) begin
      step();
      k++;
    end
    if (k >= 5000) begin
      n_chk++;
      $display("FAIL %s_timeout: %0d bursts and %0d beats still outstanding, required 0", name, exp_burst.size(), exp_beat.size());
    end
    repeat (3) step();
  endtask

  task automatic wait_beats(input string name, input int left);
    int k;
    k = 0;
    while (exp_beat.size() > left && k < 2000) begin
      step();
      k++;
    end
    if (k >= 2000) begin
      n_chk++;
      $display("FAIL %s_timeout: %0d beats outstanding, required <= %0d", name, exp_beat.size(), left);
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    exp_burst.delete();
    exp_beat.delete();
    fifo0.delete();
    fifo1.delete();
    dataq0.delete();
    dataq1.delete();
    mptr[0] = B0;
    mptr[1] = B1;
    mlast   = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int s0, r0, n0, n1;
    logic [AW-1:0] w;
    mptr[0] = B0;
    mptr[1] = B1;
    mlast   = 1'b1;
    repeat (3) step();
    chk("rst_wr_start", bus.wr_start, 1'b0);
    chk("rst_wr_addr", bus.wr_addr, 29'h0);
    chk("rst_wr_len", bus.wr_len, BL);
    chk("rst_grant", grant, 2'b00);
    chk("rst_beat_err", beat_err, 1'b0);
    rst_n = 1'b1;
    step();

    // ch0 single burst
    enable = 1'b1;
    r0 = n_rd0;
    push_words(1'b0, 32);
    expect_burst(1'b0);
    drain("single");
    chk("single_rd_en_pulses", n_rd0 - r0, 32);
    chk("single_beat_err", beat_err, 1'b0);

    // threshold and request-to-start latency
    push_words(1'b0, 31);
    s0 = n_start;
    repeat (100) step();
    chk("thresh_no_start", n_start - s0, 0);
    push_words(1'b0, 1);
    expect_burst(1'b0);
    repeat (3) @(negedge clk);
    chk("latency_early", bus.wr_start, 1'b0);
    @(negedge clk);
    chk("latency_start", bus.wr_start, 1'b1);
    drain("thresh");

    // round-robin with both channels requesting continuously
    do_reset();
    push_words(1'b0, 64);
    push_words(1'b1, 64);
    schedule(2, 2);
    enable = 1'b1;
    drain("round_robin");

    // randomized bursts on both channels (exercises wrap on both)
    for (int r = 0; r < 4; r++) begin
      enable = 1'b0;
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      push_words(1'b0, n0 * BEATS);
      push_words(1'b1, n1 * BEATS);
      schedule(n0, n1);
      enable = 1'b1;
      drain("random");
    end

    // frame wrap on ch0
    do_reset();
    push_words(1'b0, 5 * BEATS);
    schedule(5, 0);
    enable = 1'b1;
    drain("wrap");

    // frame reset during the ch0 burst at 0x800, and on idle ch1
    push_words(1'b0, BEATS);
    push_words(1'b1, BEATS);
    schedule(1, 1);
    drain("pre_frame_rst");
    push_words(1'b0, BEATS);
    expect_burst(1'b0);
    wait_beats("frame_rst_mid", 24);
    ch0_frame_rst = 1'b1;
    ch1_frame_rst = 1'b1;
    step();
    ch0_frame_rst = 1'b0;
    ch1_frame_rst = 1'b0;
    mptr[0] = B0;
    mptr[1] = B1;
    chk("ch1_ptr_rebased", dut.u_ch1_addr.ptr, B1);
    drain("frame_rst_burst");
    push_words(1'b0, BEATS);
    push_words(1'b1, BEATS);
    schedule(1, 1);
    drain("post_frame_rst");

    // short burst -> sticky beat error, then asynchronous reset mid-burst
    do_reset();
    enable = 1'b1;
    nbeats_cfg = BEATS - 1;
    push_words(1'b0, BEATS);
    expect_burst(1'b0);
    w = exp_beat.pop_back();
    dataq0.push_front(w);
    drain("beat_err");
    nbeats_cfg = BEATS;
    chk("beat_err_set", beat_err, 1'b1);
    repeat (20) step();
    chk("beat_err_sticky", beat_err, 1'b1);
    push_words(1'b0, BEATS);
    expect_burst(1'b0);
    wait_beats("async_rst_mid", 28);
    chk("mid_burst_grant", grant, 2'b01);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_grant", grant, 2'b00);
    chk("async_rst_beat_err", beat_err, 1'b0);
    chk("async_rst_wr_addr", bus.wr_addr, 29'h0);
    chk("async_rst_wr_start", bus.wr_start, 1'b0);
    chk("async_rst_wr_len", bus.wr_len, BL);
    chk("async_rst_rd_en", {ch1_fifo_rd_en, ch0_fifo_rd_en}, 2'b00);
    do_reset();
    repeat (5) step();
    chk("post_rst_beat_err", beat_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
